burst_bus_arbiter: RTL and testbench

- Two-master arbiter in front of the single burst memory controller.
- Shares the controller between the video path and a general-purpose master:
  - master 0 is the real-time video framebuffer, read-only, with priority;
  - master 1 is the debug/blitter master, read and write, with a starvation guard.
- Routes every read-return beat back to the master that issued the command, using an in-order tag queue.

---
 rtl/burst_bus_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_burst_bus_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_bus_arbiter.sv
// Two-master arbiter in front of a burst memory controller: master 0 (video, read-only, priority)
// and master 1 (read/write, starvation guard). Read beats are routed back via an in-order tag queue.
module burst_bus_arbiter #(
  parameter int BURST_LEN       = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_cmd_en,
  input  logic [20:0] m0_addr,
  output logic        m0_cmd_ready,
  output logic        m0_rd_data_valid,
  input  logic        m1_cmd_en,
  input  logic        m1_cmd,
  input  logic [20:0] m1_addr,
  input  logic [63:0] m1_wr_data,
  input  logic [7:0]  m1_data_mask,
  output logic        m1_cmd_ready,
  output logic        m1_wr_beat_req,
  output logic        m1_rd_data_valid,
  output logic [63:0] rd_data,
  output logic        mem_cmd_en,
  output logic        mem_cmd,
  output logic [20:0] mem_addr,
  output logic [63:0] mem_wr_data,
  output logic [7:0]  mem_data_mask,
  input  logic        mem_cmd_ready,
  input  logic [63:0] mem_rd_data,
  input  logic        mem_rd_data_valid,
  output logic        protocol_error
);

  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_WBEATS = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [STV_W-1:0]   r_starve_cnt;
  logic               r_tag_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_q_count;
  logic [BEAT_W-1:0]  r_rd_beat_cnt;
  logic               r_protocol_error;
  logic               r_mem_cmd_en;
  logic               r_mem_cmd;
  logic [20:0]        r_mem_addr;
  logic [63:0]        r_mem_wr_data;
  logic [7:0]         r_mem_data_mask;

  logic w_idle, w_q_full, w_q_empty, w_starved, w_m1_pri, w_can_issue;
  logic w_gnt0, w_gnt1, w_push, w_beat_ok, w_pop, w_head_tag;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign w_idle      = (r_state == ST_IDLE);
  assign w_q_full    = (r_q_count == CNT_W'(MAX_OUTSTANDING));
  assign w_q_empty   = (r_q_count == CNT_W'(0));
  assign w_starved   = (r_starve_cnt == STV_W'(STARVE_LIMIT));
  // A stale saturated counter only overrides m0 while m1 is actually still asking.
  assign w_m1_pri    = !m0_cmd_en || (m1_cmd_en && w_starved);
  assign w_can_issue = w_idle && mem_cmd_ready;
  assign w_gnt1      = w_can_issue && m1_cmd_en && w_m1_pri && (m1_cmd || !w_q_full);
  assign w_gnt0      = w_can_issue && m0_cmd_en && !w_m1_pri && !w_q_full;
  assign w_push      = w_gnt0 || (w_gnt1 && !m1_cmd);
  assign w_head_tag  = r_tag_q[r_rd_ptr];
  assign w_beat_ok   = mem_rd_data_valid && !w_q_empty;
  assign w_pop       = w_beat_ok && (r_rd_beat_cnt == BEAT_W'(BURST_LEN - 1));

  assign rd_data        = mem_rd_data;
  assign protocol_error = r_protocol_error;
  assign mem_cmd_en     = r_mem_cmd_en;
  assign mem_cmd        = r_mem_cmd;
  assign mem_addr       = r_mem_addr;
  assign mem_wr_data    = r_mem_wr_data;
  assign mem_data_mask  = r_mem_data_mask;

  // State register and write-beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= BEAT_W'(0);
    end else begin
      r_state <= w_next_state;
      if (w_gnt1 && m1_cmd) begin
        r_beat_cnt <= BEAT_W'(BURST_LEN - 1);
      end else if (r_state == ST_WBEATS) begin
        r_beat_cnt <= r_beat_cnt - BEAT_W'(1);
      end else begin
        r_beat_cnt <= r_beat_cnt;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt1 && m1_cmd) begin
          w_next_state = ST_WBEATS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WBEATS: begin
        if (r_beat_cnt == BEAT_W'(1)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WBEATS;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Per-cycle handshakes towards the masters.
  always_comb begin
    m0_cmd_ready     = w_gnt0;
    m1_cmd_ready     = w_gnt1;
    m1_wr_beat_req   = (r_state == ST_WBEATS);
    m0_rd_data_valid = w_beat_ok && (w_head_tag == 1'b0);
    m1_rd_data_valid = w_beat_ok && (w_head_tag == 1'b1);
  end

  // Registered command and write-beat path to the controller.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_cmd_en    <= 1'b0;
      r_mem_cmd       <= 1'b0;
      r_mem_addr      <= 21'd0;
      r_mem_wr_data   <= 64'd0;
      r_mem_data_mask <= 8'd0;
    end else begin
      r_mem_cmd_en <= w_gnt0 || w_gnt1;
      if (w_gnt0) begin
        r_mem_cmd  <= 1'b0;
        r_mem_addr <= m0_addr;
      end else if (w_gnt1) begin
        r_mem_cmd       <= m1_cmd;
        r_mem_addr      <= m1_addr;
        r_mem_wr_data   <= m1_wr_data;
        r_mem_data_mask <= m1_data_mask;
      end else if (r_state == ST_WBEATS) begin
        r_mem_wr_data   <= m1_wr_data;
        r_mem_data_mask <= m1_data_mask;
      end else begin
        r_mem_cmd  <= r_mem_cmd;
        r_mem_addr <= r_mem_addr;
      end
    end
  end

  // Starvation counter for master 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= STV_W'(0);
    end else if (m1_cmd_en && !w_gnt1) begin
      if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + STV_W'(1);
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= STV_W'(0);
    end
  end

  // In-order read tag queue, return-beat counter and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_tag_q[i] <= 1'b0;
      end
      r_wr_ptr         <= PTR_W'(0);
      r_rd_ptr         <= PTR_W'(0);
      r_q_count        <= CNT_W'(0);
      r_rd_beat_cnt    <= BEAT_W'(0);
      r_protocol_error <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag_q[r_wr_ptr] <= w_gnt1;
        r_wr_ptr          <= ptr_next(r_wr_ptr);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_q_count <= r_q_count + CNT_W'(1);
        2'b01:   r_q_count <= r_q_count - CNT_W'(1);
        default: r_q_count <= r_q_count;
      endcase
      if (w_pop) begin
        r_rd_beat_cnt <= BEAT_W'(0);
      end else if (w_beat_ok) begin
        r_rd_beat_cnt <= r_rd_beat_cnt + BEAT_W'(1);
      end else begin
        r_rd_beat_cnt <= r_rd_beat_cnt;
      end
      if (mem_rd_data_valid && w_q_empty) begin
        r_protocol_error <= 1'b1;
      end else begin
        r_protocol_error <= r_protocol_error;
      end
    end
  end

endmodule

// File: tb/tb_burst_bus_arbiter.sv
// Directed self-checking bench for burst_bus_arbiter (BURST_LEN 4, MAX_OUTSTANDING 4, STARVE_LIMIT 32).
module tb_burst_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_cmd_en, m0_cmd_ready, m0_rd_data_valid;
  logic [20:0] m0_addr;
  logic        m1_cmd_en, m1_cmd, m1_cmd_ready, m1_wr_beat_req, m1_rd_data_valid;
  logic [20:0] m1_addr;
  logic [63:0] m1_wr_data;
  logic [7:0]  m1_data_mask;
  logic [63:0] rd_data;
  logic        mem_cmd_en, mem_cmd, mem_cmd_ready, mem_rd_data_valid, protocol_error;
  logic [20:0] mem_addr;
  logic [63:0] mem_wr_data, mem_rd_data;
  logic [7:0]  mem_data_mask;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  burst_bus_arbiter #(.BURST_LEN(4), .MAX_OUTSTANDING(4), .STARVE_LIMIT(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cmd_en(m0_cmd_en), .m0_addr(m0_addr), .m0_cmd_ready(m0_cmd_ready),
    .m0_rd_data_valid(m0_rd_data_valid),
    .m1_cmd_en(m1_cmd_en), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_data_mask(m1_data_mask), .m1_cmd_ready(m1_cmd_ready), .m1_wr_beat_req(m1_wr_beat_req),
    .m1_rd_data_valid(m1_rd_data_valid), .rd_data(rd_data),
    .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_data_mask(mem_data_mask), .mem_cmd_ready(mem_cmd_ready), .mem_rd_data(mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid), .protocol_error(protocol_error)
  );

  function automatic logic [173:0] all_outs();
    return {mem_cmd_en, mem_cmd, mem_addr, mem_wr_data, mem_data_mask, m0_cmd_ready,
            m1_cmd_ready, m0_rd_data_valid, m1_rd_data_valid, m1_wr_beat_req, protocol_error,
            rd_data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_cmd_en = 1'b0; m0_addr = 21'd0;
    m1_cmd_en = 1'b0; m1_cmd = 1'b0; m1_addr = 21'd0;
    m1_wr_data = 64'd0; m1_data_mask = 8'd0;
    mem_cmd_ready = 1'b1; mem_rd_data = 64'd0; mem_rd_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_in();
    reset_n = 1'b0;
    #3;
    n_vec++;
    if (all_outs() !== 174'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_m0_read();
    logic [63:0] exp_d;
    do_reset();
    m0_cmd_en = 1'b1; m0_addr = 21'h000100;
    #1;
    n_vec++;
    if ({m0_cmd_ready, m1_cmd_ready} !== 2'b10) begin
      n_err++; $display("FAIL m0rd_ready: got %b expected 10", {m0_cmd_ready, m1_cmd_ready});
    end
    step();
    m0_cmd_en = 1'b0;
    n_vec++;
    if ({mem_cmd_en, mem_cmd, mem_addr} !== {1'b1, 1'b0, 21'h000100}) begin
      n_err++; $display("FAIL m0rd_cmd: got en=%b cmd=%b addr=%h expected 1 0 000100",
                        mem_cmd_en, mem_cmd, mem_addr);
    end
    step();
    n_vec++;
    if (mem_cmd_en !== 1'b0) begin
      n_err++; $display("FAIL m0rd_cmd_pulse: got %b expected 0", mem_cmd_en);
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 64'h00000000000000A0 + 64'(i);
      mem_rd_data_valid = 1'b1; mem_rd_data = exp_d;
      #1;
      n_vec++;
      if ({m0_rd_data_valid, m1_rd_data_valid, rd_data} !== {2'b10, exp_d}) begin
        n_err++; $display("FAIL m0rd_beat%0d: got v0=%b v1=%b d=%h expected 1 0 %h",
                          i, m0_rd_data_valid, m1_rd_data_valid, rd_data, exp_d);
      end
      step();
    end
    mem_rd_data_valid = 1'b0;
    #1;
    n_vec++;
    if ({m0_rd_data_valid, protocol_error} !== 2'b00) begin
      n_err++; $display("FAIL m0rd_after: got v0=%b perr=%b expected 0 0",
                        m0_rd_data_valid, protocol_error);
    end
  endtask

  task automatic test_starvation();
    logic exp0;
    do_reset();
    m0_cmd_en = 1'b1; m0_addr = 21'h000040;
    m1_cmd_en = 1'b1; m1_cmd = 1'b1; m1_addr = 21'h000080; m1_wr_data = 64'h5A;
    for (int c = 1; c <= 37; c++) begin
      mem_rd_data_valid = (c >= 2);
      mem_rd_data = 64'(c);
      #1;
      exp0 = (c <= 4) || (c >= 6 && c <= 30 && ((c - 6) % 4) == 0) || (c == 37);
      n_vec++;
      if (m1_cmd_ready !== (c == 33)) begin
        n_err++; $display("FAIL starve_m1_ready c%0d: got %b expected %b",
                          c, m1_cmd_ready, (c == 33));
      end
      n_vec++;
      if (m0_cmd_ready !== exp0) begin
        n_err++; $display("FAIL starve_m0_ready c%0d: got %b expected %b", c, m0_cmd_ready, exp0);
      end
      step();
    end
    n_vec++;
    if (protocol_error !== 1'b0) begin
      n_err++; $display("FAIL starve_perr: got %b expected 0", protocol_error);
    end
  endtask

  task automatic test_write();
    do_reset();
    m1_cmd_en = 1'b1; m1_cmd = 1'b1; m1_addr = 21'h001234;
    m1_wr_data = 64'h11; m1_data_mask = 8'h00;
    #1;
    n_vec++;
    if ({m1_cmd_ready, m1_wr_beat_req} !== 2'b10) begin
      n_err++; $display("FAIL wr_accept: got rdy=%b req=%b expected 1 0", m1_cmd_ready, m1_wr_beat_req);
    end
    step();
    m1_cmd_en = 1'b0; m0_cmd_en = 1'b1; m0_addr = 21'h000200;
    m1_wr_data = 64'h22; m1_data_mask = 8'h00;
    #1;
    n_vec++;
    if ({mem_cmd_en, mem_cmd, mem_addr, mem_wr_data, mem_data_mask, m1_wr_beat_req, m0_cmd_ready}
        !== {1'b1, 1'b1, 21'h001234, 64'h11, 8'h00, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL wr_beat0: got en=%b cmd=%b a=%h d=%h m=%h req=%b r0=%b",
                        mem_cmd_en, mem_cmd, mem_addr, mem_wr_data, mem_data_mask,
                        m1_wr_beat_req, m0_cmd_ready);
    end
    step();
    m1_wr_data = 64'h33; m1_data_mask = 8'h0F;
    #1;
    n_vec++;
    if ({mem_cmd_en, mem_wr_data, mem_data_mask, m1_wr_beat_req, m0_cmd_ready}
        !== {1'b0, 64'h22, 8'h00, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL wr_beat1: got en=%b d=%h m=%h req=%b r0=%b expected 0 22 00 1 0",
                        mem_cmd_en, mem_wr_data, mem_data_mask, m1_wr_beat_req, m0_cmd_ready);
    end
    step();
    m1_wr_data = 64'h44; m1_data_mask = 8'h00;
    #1;
    n_vec++;
    if ({mem_wr_data, mem_data_mask, m1_wr_beat_req, m0_cmd_ready}
        !== {64'h33, 8'h0F, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL wr_beat2: got d=%h m=%h req=%b r0=%b expected 33 0f 1 0",
                        mem_wr_data, mem_data_mask, m1_wr_beat_req, m0_cmd_ready);
    end
    step();
    m1_wr_data = 64'hEE;
    #1;
    n_vec++;
    if ({mem_wr_data, mem_data_mask, m1_wr_beat_req, m0_cmd_ready}
        !== {64'h44, 8'h00, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL wr_beat3: got d=%h m=%h req=%b r0=%b expected 44 00 0 1",
                        mem_wr_data, mem_data_mask, m1_wr_beat_req, m0_cmd_ready);
    end
    step();
    m0_cmd_en = 1'b0;
    #1;
    n_vec++;
    if ({mem_cmd_en, mem_cmd, mem_addr} !== {1'b1, 1'b0, 21'h000200}) begin
      n_err++; $display("FAIL wr_m0_resume: got en=%b cmd=%b a=%h expected 1 0 000200",
                        mem_cmd_en, mem_cmd, mem_addr);
    end
  endtask

  task automatic test_queue_full();
    logic exp_m0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      m0_cmd_en = (c % 2 == 0); m0_addr = 21'(c + 1);
      m1_cmd_en = (c % 2 == 1); m1_cmd = 1'b0; m1_addr = 21'(c + 1);
      #1;
      n_vec++;
      if ({m0_cmd_ready, m1_cmd_ready} !== {(c % 2 == 0), (c % 2 == 1)}) begin
        n_err++; $display("FAIL qf_issue%0d: got %b%b", c, m0_cmd_ready, m1_cmd_ready);
      end
      step();
    end
    m0_cmd_en = 1'b1; m1_cmd_en = 1'b1;
    #1;
    n_vec++;
    if ({m0_cmd_ready, m1_cmd_ready} !== 2'b00) begin
      n_err++; $display("FAIL qf_fifth: got %b%b expected 00", m0_cmd_ready, m1_cmd_ready);
    end
    step();
    for (int b = 0; b < 4; b++) begin
      exp_m0 = (b % 2 == 0);
      for (int i = 0; i < 4; i++) begin
        mem_rd_data_valid = 1'b1; mem_rd_data = 64'(16 * b + i);
        #1;
        n_vec++;
        if ({m0_rd_data_valid, m1_rd_data_valid} !== {exp_m0, !exp_m0}) begin
          n_err++; $display("FAIL qf_route b%0d i%0d: got %b%b expected %b%b",
                            b, i, m0_rd_data_valid, m1_rd_data_valid, exp_m0, !exp_m0);
        end
        if (b == 0) begin
          n_vec++;
          if (m0_cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL qf_block i%0d: got %b expected 0", i, m0_cmd_ready);
          end
        end
        step();
      end
      if (b == 0) begin
        mem_rd_data_valid = 1'b0; m1_cmd_en = 1'b0;
        #1;
        n_vec++;
        if (m0_cmd_ready !== 1'b1) begin
          n_err++; $display("FAIL qf_ready_after_pop: got %b expected 1", m0_cmd_ready);
        end
        step();
        m0_cmd_en = 1'b0;
      end
    end
    mem_rd_data_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_cmd_ready = 1'b0;
    m0_cmd_en = 1'b1; m0_addr = 21'h0ABCDE;
    m1_cmd_en = 1'b1; m1_cmd = 1'b0; m1_addr = 21'h011111;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_vec++;
      if ({m0_cmd_ready, m1_cmd_ready, mem_cmd_en} !== 3'b000) begin
        n_err++; $display("FAIL bp_stall c%0d: got %b%b%b expected 000",
                          c, m0_cmd_ready, m1_cmd_ready, mem_cmd_en);
      end
      step();
    end
    mem_cmd_ready = 1'b1;
    #1;
    n_vec++;
    if ({m0_cmd_ready, m1_cmd_ready} !== 2'b10) begin
      n_err++; $display("FAIL bp_release: got %b%b expected 10", m0_cmd_ready, m1_cmd_ready);
    end
    step();
    m0_cmd_en = 1'b0; m1_cmd_en = 1'b0;
    n_vec++;
    if ({mem_cmd_en, mem_addr} !== {1'b1, 21'h0ABCDE}) begin
      n_err++; $display("FAIL bp_cmd: got en=%b a=%h expected 1 0abcde", mem_cmd_en, mem_addr);
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    m0_cmd_en = 1'b1; m0_addr = 21'h000010;
    step();
    m0_cmd_en = 1'b0; m1_cmd_en = 1'b1; m1_cmd = 1'b0; m1_addr = 21'h000020;
    step();
    idle_in();
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (all_outs() !== 174'd0) begin
      n_err++; $display("FAIL rstmid_outputs: got %h expected 0", all_outs());
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rd_data_valid = 1'b1; mem_rd_data = 64'hC0 + 64'(i);
      #1;
      n_vec++;
      if ({m0_rd_data_valid, m1_rd_data_valid, protocol_error} !== {2'b00, (i != 0)}) begin
        n_err++; $display("FAIL rstmid_beat%0d: got v0=%b v1=%b perr=%b expected 0 0 %b",
                          i, m0_rd_data_valid, m1_rd_data_valid, protocol_error, (i != 0));
      end
      step();
    end
    mem_rd_data_valid = 1'b0;
    #1;
    n_vec++;
    if (protocol_error !== 1'b1) begin
      n_err++; $display("FAIL rstmid_sticky: got %b expected 1", protocol_error);
    end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_starvation();
    test_write();
    test_queue_full();
    test_backpressure();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
